booth_r4_ctrl: RTL and testbench

Control-and-accumulator stage of the radix-4 Booth multiplier. It sits directly upstream of the 2-bit right-shift register that holds the multiplier and the low product half. It drives that register's set/shift/shift_in/din controls and reads back its contents. Each iteration it recodes 3 multiplier bits, adds 0/±M/±2M into an (N+2)-bit accumulator, and arithmetic-shifts the combined {acc, Q} right by 2. It delivers a signed 2N-bit product with a start/busy/done handshake.

---
 rtl/booth_pkg.sv | 30 +++
 rtl/booth_r4_ctrl_if.sv | 14 +
 rtl/booth_r4_recode.sv | 31 +++
 rtl/booth_r4_ctrl.sv | 102 ++++++++++
 tb/tb_booth_r4_ctrl.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM encoding and the
// partial-product select codes produced by the recoder.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PP_ZERO = 3'd0,
        PP_POS1 = 3'd1,
        PP_POS2 = 3'd2,
        PP_NEG1 = 3'd3,
        PP_NEG2 = 3'd4
    } pp_sel_t;

    // Window is {q[i+1], q[i], q[i-1]}.
    function automatic pp_sel_t recode_sel(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: recode_sel = PP_POS1;
            3'b011:         recode_sel = PP_POS2;
            3'b100:         recode_sel = PP_NEG2;
            3'b101, 3'b110: recode_sel = PP_NEG1;
            default:        recode_sel = PP_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_ctrl_if.sv
// Start/busy/done request bus of the Booth multiplier control stage.
interface booth_r4_ctrl_if #(parameter int N = 8);
    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    modport master (output start, multiplicand, multiplier,
                    input  busy, done, product);
    modport slave  (input  start, multiplicand, multiplier,
                    output busy, done, product);
endinterface

// File: rtl/booth_r4_recode.sv
// Combinational radix-4 Booth recoder: 3-bit window plus M to an (N+2)-bit
// partial product in {0, +-M, +-2M}.
module booth_r4_recode
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [2:0]   win,
    input  logic [N-1:0] m,
    output logic [N+1:0] pp
);

    logic [N+1:0] m1;
    logic [N+1:0] m2;

    // Sign-extend first so that 2M and -(-2^(N-1)) stay representable.
    assign m1 = {{2{m[N-1]}}, m};
    assign m2 = {m1[N:0], 1'b0};

    always_comb begin
        pp = '0;
        case (recode_sel(win))
            PP_POS1: pp = m1;
            PP_POS2: pp = m2;
            PP_NEG1: pp = -m1;
            PP_NEG2: pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_r4_ctrl.sv
// Radix-4 Booth control and accumulator stage. Drives an external 2-bit
// right-shift register holding the multiplier / low product half.
module booth_r4_ctrl
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst,
    booth_r4_ctrl_if.slave      bus,
    output logic                q_set,
    output logic                q_shift,
    output logic [1:0]          q_shift_in,
    output logic [N-1:0]        q_din,
    input  logic [N-1:0]        q_dout
);

    localparam int            CW   = $clog2(N/2);
    localparam logic [CW-1:0] LAST = CW'(N/2 - 1);

    state_t         state, state_nx;
    logic [N-1:0]   m_reg;
    logic [N+1:0]   acc, pp, sum, acc_nx;
    logic           q_m1;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] product;

    booth_r4_recode #(.N(N)) u_recode (
        .win ({q_dout[1:0], q_m1}),
        .m   (m_reg),
        .pp  (pp)
    );

    assign sum    = acc + pp;
    assign acc_nx = $signed(sum) >>> 2;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        q_set      = 1'b0;
        q_shift    = 1'b0;
        q_shift_in = 2'b00;
        q_din      = '0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    q_set    = 1'b1;
                    q_din    = bus.multiplier;
                    state_nx = ITER;
                end
            end
            ITER: begin
                q_shift    = 1'b1;
                q_din      = q_dout;
                q_shift_in = sum[1:0];
                if (cnt == LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg   <= '0;
            acc     <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.multiplicand;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ITER: begin
                    acc  <= acc_nx;
                    q_m1 <= q_dout[1];
                    cnt  <= cnt + 1'b1;
                    // Final iteration: the register only holds the new low half
                    // after this edge, so assemble it from the shift inputs.
                    if (cnt == LAST)
                        product <= {acc_nx[N-1:0], sum[1:0], q_dout[N-1:2]};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.product = product;

endmodule

// File: tb/tb_booth_r4_ctrl.sv
// Self-checking bench for booth_r4_ctrl at N=8 and N=16, each instance wired
// to a behavioural 2-bit right-shift register.
module tb_booth_r4_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    booth_r4_ctrl_if #(.N(8))  bus8 ();
    booth_r4_ctrl_if #(.N(16)) bus16 ();

    logic        q_set8, q_shift8;
    logic [1:0]  q_shift_in8;
    logic [7:0]  q_din8, sr8;
    logic        q_set16, q_shift16;
    logic [1:0]  q_shift_in16;
    logic [15:0] q_din16, sr16;

    booth_r4_ctrl #(.N(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave),
        .q_set(q_set8), .q_shift(q_shift8), .q_shift_in(q_shift_in8),
        .q_din(q_din8), .q_dout(sr8)
    );

    booth_r4_ctrl #(.N(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave),
        .q_set(q_set16), .q_shift(q_shift16), .q_shift_in(q_shift_in16),
        .q_din(q_din16), .q_dout(sr16)
    );

    // Downstream shift registers (no reset)
    always @(posedge clk) begin
        if (q_set8)        sr8 <= q_din8;
        else if (q_shift8) sr8 <= {q_shift_in8, q_din8[7:2]};
        if (q_set16)        sr16 <= q_din16;
        else if (q_shift16) sr16 <= {q_shift_in16, q_din16[15:2]};
    end

    // Per-cycle strobe monitor: load only when an idle block sees start,
    // shifts only while working, exactly N/2 shifts before each done.
    int sh8 = 0, sh16 = 0;
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            sh8 = 0; sh16 = 0;
        end else begin
            checks++;
            if (q_set8 !== (bus8.start && !bus8.busy)) begin
                failures++;
                $display("FAIL q_set8_gate: got %b expected %b", q_set8, bus8.start && !bus8.busy);
            end
            checks++;
            if (q_shift8 && (!bus8.busy || bus8.done || q_set8)) begin
                failures++;
                $display("FAIL q_shift8_gate: got 1 busy=%b done=%b set=%b", bus8.busy, bus8.done, q_set8);
            end
            if (q_set8) sh8 = 0;
            if (q_shift8) sh8++;
            if (bus8.done) begin
                checks++;
                if (sh8 !== 4) begin
                    failures++;
                    $display("FAIL shift_count8: got %0d expected 4", sh8);
                end
            end
            checks++;
            if (q_set16 !== (bus16.start && !bus16.busy)) begin
                failures++;
                $display("FAIL q_set16_gate: got %b expected %b", q_set16, bus16.start && !bus16.busy);
            end
            checks++;
            if (q_shift16 && (!bus16.busy || bus16.done || q_set16)) begin
                failures++;
                $display("FAIL q_shift16_gate: got 1 busy=%b done=%b set=%b", bus16.busy, bus16.done, q_set16);
            end
            if (q_set16) sh16 = 0;
            if (q_shift16) sh16++;
            if (bus16.done) begin
                checks++;
                if (sh16 !== 8) begin
                    failures++;
                    $display("FAIL shift_count16: got %0d expected 8", sh16);
                end
            end
        end
    end

    // Stimulus drivers: enter and leave 1 time unit after a rising edge,
    // leaving the block back in IDLE on return.
    task automatic op8(input logic [7:0] m, input logic [7:0] q,
                       output logic [15:0] p, output int lat, output bit ok);
        bus8.start = 1'b1; bus8.multiplicand = m; bus8.multiplier = q;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        ok = 1'b0; lat = 0; p = '0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (bus8.done) begin ok = 1'b1; lat = k + 1; p = bus8.product; end
            @(posedge clk); #1;
        end
    endtask

    task automatic op16(input logic [15:0] m, input logic [15:0] q,
                        output logic [31:0] p, output int lat, output bit ok);
        bus16.start = 1'b1; bus16.multiplicand = m; bus16.multiplier = q;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        ok = 1'b0; lat = 0; p = '0;
        for (int k = 0; k < 30 && !ok; k++) begin
            if (bus16.done) begin ok = 1'b1; lat = k + 1; p = bus16.product; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus8.busy, bus8.done, q_set8, q_shift8, q_shift_in8} !== 6'b0 || q_din8 !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs8: got busy=%b done=%b set=%b shift=%b sin=%b din=%h expected all 0",
                     bus8.busy, bus8.done, q_set8, q_shift8, q_shift_in8, q_din8);
        end
        checks++;
        if (bus8.product !== 16'h0 || bus16.product !== 32'h0) begin
            failures++;
            $display("FAIL reset_product: got %h/%h expected 0", bus8.product, bus16.product);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus8.busy !== 1'b0 || bus16.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy %b/%b expected 0", bus8.busy, bus16.busy);
        end
    endtask

    task automatic test_directed();
        logic [7:0]  tm [5] = '{8'h03, 8'h80, 8'h80, 8'h00, 8'h55};
        logic [7:0]  tq [5] = '{8'h05, 8'h80, 8'h7F, 8'hA5, 8'h00};
        logic [15:0] te [5] = '{16'h000F, 16'h4000, 16'hC080, 16'h0000, 16'h0000};
        logic [15:0] p;
        int lat;
        bit ok;
        for (int i = 0; i < 5; i++) begin
            op8(tm[i], tq[i], p, lat, ok);
            checks++;
            if (!ok || lat != 5) begin
                failures++;
                $display("FAIL latency_%0d: got ok=%b lat=%0d expected lat=5", i, ok, lat);
            end
            checks++;
            if (p !== te[i]) begin
                failures++;
                $display("FAIL product_%0d: got %h expected %h", i, p, te[i]);
            end
            checks++;
            if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.product !== te[i]) begin
                failures++;
                $display("FAIL after_done_%0d: got busy=%b done=%b product=%h expected 0 0 %h",
                         i, bus8.busy, bus8.done, bus8.product, te[i]);
            end
        end
    endtask

    task automatic test_start_held();
        int dones = 0;
        int accepted = 0;
        bit drop = 1'b0;
        bus8.start = 1'b1; bus8.multiplicand = 8'h07; bus8.multiplier = 8'hFD; // 7*-3
        @(posedge clk); #1;
        bus8.multiplicand = 8'hF6; bus8.multiplier = 8'h0C;                   // -10*12
        for (int k = 0; k < 40; k++) begin
            if (drop) begin bus8.start = 1'b0; drop = 1'b0; end
            if (bus8.done) begin
                dones++;
                checks++;
                if (bus8.product !== (dones == 1 ? 16'hFFEB : 16'hFF88)) begin
                    failures++;
                    $display("FAIL held_product_%0d: got %h expected %h", dones, bus8.product,
                             (dones == 1 ? 16'hFFEB : 16'hFF88));
                end
            end
            if (bus8.start && !bus8.busy) begin
                accepted++;
                drop = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus8.start = 1'b0;
        checks++;
        if (dones != 2 || accepted != 1) begin
            failures++;
            $display("FAIL held_done_count: got dones=%0d reaccepts=%0d expected 2 1", dones, accepted);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        bit ok;
        int dones = 0;
        bus8.start = 1'b1; bus8.multiplicand = 8'h05; bus8.multiplier = 8'h03;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || q_shift8 !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b done=%b shift=%b expected 0", bus8.busy, bus8.done, q_shift8);
        end
        for (int k = 0; k < 8; k++) begin
            if (bus8.done) dones++;
            @(posedge clk); #1;
        end
        checks++;
        if (dones != 0 || bus8.product !== 16'h0) begin
            failures++;
            $display("FAIL abort_no_done: got dones=%0d product=%h expected 0 0", dones, bus8.product);
        end
        op8(8'hF9, 8'h09, p, lat, ok);
        checks++;
        if (!ok || p !== 16'hFFC1) begin
            failures++;
            $display("FAIL after_abort: got ok=%b product=%h expected FFC1", ok, p);
        end
    endtask

    task automatic test_random8();
        logic [7:0]  m, q;
        logic [15:0] p, e;
        int lat;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            m = 8'($urandom); q = 8'($urandom);
            if (i % 50 == 0) m = (i % 100 == 0) ? 8'h80 : 8'h7F;
            e = 16'(longint'($signed(m)) * longint'($signed(q)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            op8(m, q, p, lat, ok);
            checks++;
            if (!ok || lat != 5 || p !== e) begin
                failures++;
                $display("FAIL rand8 %h*%h: got ok=%b lat=%0d product=%h expected lat=5 %h", m, q, ok, lat, p, e);
            end
        end
    endtask

    task automatic test_random16();
        logic [15:0] m, q;
        logic [31:0] p, e;
        int lat;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            m = 16'($urandom); q = 16'($urandom);
            if (i % 50 == 0) q = (i % 100 == 0) ? 16'h8000 : 16'h7FFF;
            e = 32'(longint'($signed(m)) * longint'($signed(q)));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            op16(m, q, p, lat, ok);
            checks++;
            if (!ok || lat != 9 || p !== e) begin
                failures++;
                $display("FAIL rand16 %h*%h: got ok=%b lat=%0d product=%h expected lat=9 %h", m, q, ok, lat, p, e);
            end
        end
    endtask

    initial begin
        bus8.start = 1'b0;  bus8.multiplicand = '0;  bus8.multiplier = '0;
        bus16.start = 1'b0; bus16.multiplicand = '0; bus16.multiplier = '0;
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid();
        test_random8();
        test_random16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
